m_sequence_checker_15_4: RTL
============================

# m_sequence_checker_15_4

Receive-side checker for the 15-bit maximal-length sequence produced by the 4-bit LFSR generator (recurrence b[n] = b[n-3] XOR b[n-4]). It sits directly downstream of the generator, or of the link carrying its output. It self-synchronises to the incoming bit stream, declares lock, and flags individual bit errors once locked. It accumulates a saturating error count and drops lock when the error density becomes too high.

## Interface
- LOCK_BITS, 15: consecutive correctly predicted bits required to declare lock.
- WINDOW, 15: length in valid bits of the loss-of-lock evaluation window.
- LOSS_ERRORS, 4: errors within one window that force loss of lock (1..WINDOW).
- COUNT_W, 16: width of error_count.
- clock  input  1  single clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high.
- in  input  1  received sequence bit.
- in_valid  input  1  qualifies in; bits are sampled only on edges where in_valid=1. Tie high when driven directly by the generator.
- clear  input  1  synchronous clear of error_count only.
- locked  output  1  registered; high while in LOCKED.
- bit_error  output  1  registered one-cycle pulse per mismatched bit while LOCKED.
- error_count  output  COUNT_W  registered; saturating count of bit_error pulses.

## Operation
- Reference sequence from generator reset, one period: 1,1,0,1,0,1,1,1,1,0,0,0,1,0,0. Any cyclic shift of it is a valid stream.
- FSM states: LOAD, VERIFY, LOCKED. Reset enters LOAD and clears all counters. Nothing advances when in_valid=0.
- LOAD: shift valid bits into the 4-bit history h.
  - After the 4th bit, go to VERIFY with run count 0.
  - If the 4 loaded bits are 0000, stay in LOAD and restart the fill. An all-zero stream must never lock.
- VERIFY: for each valid bit, prediction p = h[n-3] XOR h[n-4], taken from the received history. Then shift in the received bit.
  - Match: increment the run count. At LOCK_BITS matches, go to LOCKED and copy h into the local LFSR.
  - Mismatch: go to LOAD with the fill count set to 0.
  - If h becomes 0000, treat it as a mismatch.
- LOCKED: the local LFSR free-runs on its own predictions, advancing once per valid bit. Received errors never enter it, so a single flipped bit yields exactly one error.
  - Compare the received bit with the prediction. On mismatch, pulse bit_error and increment both error_count and the window error count.
  - Window counter runs 0..WINDOW-1 over valid bits. The bit at index WINDOW-1 belongs to the current window; after it, both the window counter and the window error count reset to 0.
  - If the window error count reaches LOSS_ERRORS, go to LOAD and discard the history.
- error_count increments only in LOCKED, saturates at 2^COUNT_W-1, and is cleared only by reset or clear.
  - clear and an error on the same edge: clear wins, so the result is 0.
  - clear has no effect on the FSM or the window counters.
- Reset mid-operation: state, history, counters and all outputs return to reset values on that edge.

## Timing
- Reset values: locked=0, bit_error=0, error_count=0, state LOAD.
- Lock latency on a clean stream: locked rises on the edge that samples the (4+LOCK_BITS)th valid bit, i.e. the 19th with defaults. It is visible the cycle after that bit is presented.
- bit_error is high for exactly the cycle following the edge that sampled the bad bit. Gaps in in_valid do not stretch it.
- Loss: locked falls on the same edge that samples the LOSS_ERRORS-th error of a window. That error still produces its bit_error pulse and count increment.
- Throughput: one bit per clock. There is no backpressure.

## Test plan
- Generator output (reset 0011) fed continuously with in_valid=1 -> locked=1 after the 19th sampled bit; no bit_error over 1000 bits; error_count=0.
- Locked stream, one bit inverted at bit 40 -> a single bit_error pulse one cycle later; error_count=1; locked stays 1. The next bit is checked correctly, with no error propagation.
- Locked stream, 4 bits inverted within one 15-bit window -> 4 pulses; error_count=4; locked drops on the 4th. Relock occurs 19 valid bits later.
- 3 errors in one window followed by 1 in the next -> locked stays 1; error_count=4.
- Input stuck at 0, then stuck at 1 -> locked never asserts. Alternating 0101 -> never locks.
- in_valid toggled 50% with a random pattern -> lock after 19 valid bits. Then clear coinciding with an injected error -> error_count=0. Then reset while locked -> locked=0, error_count=0 on the next cycle.

Source files
------------

// File: rtl/m_sequence_checker_15_4_if.sv
// Bundles the received bit stream, its qualifier and the clear input with the
// checker's status outputs.
interface m_sequence_checker_15_4_if #(
  parameter int COUNT_W = 16
);
  logic               in;
  logic               in_valid;
  logic               clear;
  logic               locked;
  logic               bit_error;
  logic [COUNT_W-1:0] error_count;

  modport master (
    output in, in_valid, clear,
    input  locked, bit_error, error_count
  );

  modport slave (
    input  in, in_valid, clear,
    output locked, bit_error, error_count
  );
endinterface

// File: rtl/m_sequence_checker_15_4.sv
// Receive-side checker for the 15-bit m-sequence b[n] = b[n-3] ^ b[n-4].
// Self-synchronises from the received history, then tracks the stream with
// a free-running local LFSR so that each flipped bit yields exactly one error.
// Lock is dropped when one evaluation window collects too many errors.
module m_sequence_checker_15_4 #(
  parameter int LOCK_BITS   = 15,
  parameter int WINDOW      = 15,
  parameter int LOSS_ERRORS = 4,
  parameter int COUNT_W     = 16
) (
  input logic                    clock,
  input logic                    reset,
  m_sequence_checker_15_4_if.slave bus
);

  localparam int RUN_W = $clog2(LOCK_BITS + 1);
  localparam int WIN_W = $clog2(WINDOW + 1);
  localparam int ERR_W = $clog2(LOSS_ERRORS + 1);

  typedef enum logic [1:0] {
    LOAD,
    VERIFY,
    LOCKED
  } state_t;

  state_t           state;
  logic [3:0]       hist;
  logic [3:0]       lfsr;
  logic [1:0]       fill;
  logic [RUN_W-1:0] run;
  logic [WIN_W-1:0] win_idx;
  logic [ERR_W-1:0] win_err;

  logic [3:0]       hist_next;
  logic             hist_pred;
  logic             lfsr_pred;
  logic             miss;
  logic [ERR_W-1:0] win_err_next;
  logic             count_sat;
  logic             count_inc;

  // hist[3] is the oldest bit b[n-4], hist[0] the newest b[n-1]
  assign hist_next    = {hist[2:0], bus.in};
  assign hist_pred    = hist[3] ^ hist[2];
  assign lfsr_pred    = lfsr[3] ^ lfsr[2];
  assign miss         = bus.in != lfsr_pred;
  assign win_err_next = win_err + ERR_W'(miss);
  assign count_sat    = &bus.error_count;
  assign count_inc    = bus.in_valid && (state == LOCKED) && miss;

  // Acquisition/tracking state machine; nothing but bit_error moves on invalid cycles
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= LOAD;
      hist          <= 4'd0;
      lfsr          <= 4'd0;
      fill          <= 2'd0;
      run           <= '0;
      win_idx       <= '0;
      win_err       <= '0;
      bus.locked    <= 1'b0;
      bus.bit_error <= 1'b0;
    end else begin
      bus.bit_error <= 1'b0;
      if (bus.in_valid) begin
        case (state)
          LOAD: begin
            hist <= hist_next;
            if (fill == 2'd3) begin
              fill <= 2'd0;
              if (hist_next != 4'd0) begin
                state <= VERIFY;
                run   <= '0;
              end
            end else begin
              fill <= fill + 2'd1;
            end
          end
          VERIFY: begin
            hist <= hist_next;
            if ((bus.in != hist_pred) || (hist_next == 4'd0)) begin
              state <= LOAD;
              fill  <= 2'd0;
            end else if (run == RUN_W'(LOCK_BITS - 1)) begin
              state      <= LOCKED;
              bus.locked <= 1'b1;
              lfsr       <= hist_next;
              win_idx    <= '0;
              win_err    <= '0;
            end else begin
              run <= run + RUN_W'(1);
            end
          end
          LOCKED: begin
            lfsr          <= {lfsr[2:0], lfsr_pred};
            bus.bit_error <= miss;
            if (win_err_next == ERR_W'(LOSS_ERRORS)) begin
              state      <= LOAD;
              bus.locked <= 1'b0;
              fill       <= 2'd0;
              hist       <= 4'd0;
              win_idx    <= '0;
              win_err    <= '0;
            end else if (win_idx == WIN_W'(WINDOW - 1)) begin
              win_idx <= '0;
              win_err <= '0;
            end else begin
              win_idx <= win_idx + WIN_W'(1);
              win_err <= win_err_next;
            end
          end
          default: begin
            state      <= LOAD;
            bus.locked <= 1'b0;
            fill       <= 2'd0;
          end
        endcase
      end
    end
  end

  // Saturating error tally; clear overrides a simultaneous increment
  always_ff @(posedge clock) begin
    if (reset || bus.clear) begin
      bus.error_count <= '0;
    end else if (count_inc && !count_sat) begin
      bus.error_count <= bus.error_count + COUNT_W'(1);
    end
  end

endmodule
